preamble_gen: RTL and testbench
===============================

Name: preamble_gen

Overview:
- Transmit-side counterpart of the decimated autocorrelation preamble detector.
- On a start strobe, emits a repeated QPSK pseudo-random preamble on an IQ AXI-stream, then passes the payload packet through unchanged.
- Each symbol is held for INTERP_RATE samples, so at the receiver's decimated rate the preamble halves repeat with period LEN.
- Sits ahead of the DUC/radio TX path, with IQ split into I and Q buses as in the RX chain.

Parameters:
- DATA_WIDTH, 16: I/Q sample width (two's complement).
- MAX_LEN, 4095: maximum symbols per repetition; sizes counters.
- LEN, 4092: symbols per repetition; must match the detector LEN; range 1..MAX_LEN.
- INTERP_RATE, 64: samples per symbol (zero-order hold); must equal the detector DEC_RATE; range 1..255.
- NREP, 2: identical repetitions; range 2..15.
- AMPL, 16'h2000: QPSK magnitude on each rail.
- LFSR_SEED, 16'hACE1: reloaded at the start of every repetition; must be nonzero.
- GUARD_LEN, 256: zero samples after the preamble; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous flush; same effect as reset
- start  in  1  one-cycle request; honoured only in IDLE
- in_tvalid  in  1  payload valid
- in_tlast  in  1  last payload sample
- in_tready  out  1  payload ready
- in_itdata  in  DATA_WIDTH  payload I
- in_qtdata  in  DATA_WIDTH  payload Q
- out_tvalid  out  1  output valid
- out_tlast  out  1  last payload sample out
- out_tready  in  1  downstream ready
- out_itdata  out  DATA_WIDTH  output I
- out_qtdata  out  DATA_WIDTH  output Q
- busy  out  1  high whenever state is not IDLE
- preamble_stb  out  1  one-cycle pulse on the first preamble sample handshake

Behaviour:
- Clock is clk. Reset is synchronous and active-high. reset or clear: state=IDLE; all counters 0; LFSR=LFSR_SEED; out_tvalid=0, out_tlast=0, out data=0, in_tready=0, busy=0, preamble_stb=0. Reset mid-packet aborts immediately, with no tlast emitted.
- States: IDLE, PRE, GUARD (only with the optional feature), PAY.
- IDLE:
  - in_tready=0, out_tvalid=0.
  - start -> PRE on the next cycle, LFSR loaded with LFSR_SEED.
  - Payload arriving in IDLE is held off via backpressure.
- PRE:
  - out_tvalid=1, out_tlast=0.
  - Data: I = lfsr[0] ? -AMPL : +AMPL; Q = lfsr[1] ? -AMPL : +AMPL.
  - Data is registered and must stay stable while out_tready=0.
  - Counters hold_cnt (0..INTERP_RATE-1), sym_cnt (0..LEN-1) and rep_cnt (0..NREP-1) advance only on an out handshake.
  - On hold_cnt wrap, the LFSR steps once: Fibonacci, fb = l[0]^l[2]^l[3]^l[5], next = {fb, l[15:1]}.
  - On sym_cnt wrap, the LFSR reloads LFSR_SEED, so the repetitions are bit-identical.
  - After the final handshake -> PAY (or GUARD).
- PAY:
  - Combinational passthrough: out_*data=in_*data, out_tvalid=in_tvalid, out_tlast=in_tlast, in_tready=out_tready.
  - Handshake with in_tlast=1 -> IDLE.
- Preamble length = LEN*INTERP_RATE*NREP samples.
- No bubbles: with out_tready held high, one sample per cycle, including across the PRE->PAY boundary.
- Latency: start to first out_tvalid is 1 cycle.
- Simultaneity:
  - start while busy is ignored, not queued.
  - clear has priority over start.
  - A start coinciding with the final payload handshake is ignored.
- Negation of AMPL: plain two's complement. AMPL must not be the most-negative value.

Optional Feature:
- Macro: PREAMBLE_GEN_GUARD_EN.
- Defined: PRE -> GUARD, which emits GUARD_LEN zero samples (out_tvalid=1, handshake-counted), then -> PAY. This gives the detector's moving averages settling time.
- Undefined: the GUARD state and its counter are absent; PRE -> PAY directly.

Decomposition:
- Shared package: state encoding, LFSR polynomial taps, and the default LFSR seed constant, reused by the testbench reference model.
- Natural sub-module: preamble_lfsr_qpsk. It holds the seed load, step enable, and QPSK mapping to {I,Q}.

Test Plan:
- LEN=4, INTERP_RATE=2, NREP=2, out_tready=1, start pulse -> 16 preamble samples.
  - First two samples: I=16'hE000, Q=16'h2000 (seed 0xACE1).
  - Samples 3-4: 16'h2000/16'h2000 (LFSR 0x5670).
  - Samples 9-16 identical to samples 1-8.
  - preamble_stb pulses once.
- Same setup, then a 5-sample payload I=1..5 with tlast on 5 -> out I=1..5 immediately after preamble sample 16, out_tlast only on 5, then busy=0.
- Random out_tready (50%) -> output sequence identical to the back-to-back case. Data must be stable while out_tvalid&!out_tready; no in_tready during PRE.
- start pulsed mid-preamble and mid-payload -> ignored; total samples unchanged.
- reset asserted at preamble sample 6 -> next cycle out_tvalid=0, busy=0. A fresh start then restarts from the seed (I=16'hE000).
- With PREAMBLE_GEN_GUARD_EN and GUARD_LEN=3 -> exactly 3 zero samples between preamble sample 16 and payload sample 1.

Source files
------------

// File: rtl/preamble_gen_pkg.sv
// Shared constants for the QPSK preamble generator:
// state encoding, LFSR feedback taps and default seed.
package preamble_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_PAY   = 2'd3;

    // Fibonacci feedback taps: bits 0, 2, 3, 5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {^(l & LFSR_TAPS), l[15:1]};
    endfunction

endpackage

// File: rtl/preamble_gen_lfsr_qpsk.sv
// LFSR symbol source with seed load, step enable and
// registered QPSK mapping of lfsr[1:0] onto {I,Q}.
import preamble_gen_pkg::*;

module preamble_lfsr_qpsk #(
    parameter int              DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] AMPL = 16'h2000,
    parameter logic [15:0]     LFSR_SEED  = LFSR_DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] q_data
);

    localparam logic [DATA_WIDTH-1:0] POS = AMPL;
    localparam logic [DATA_WIDTH-1:0] NEG = -AMPL;

    logic [15:0]           lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] i_q, i_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;

    // Next LFSR value and its symbol mapping; load wins over step
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = LFSR_SEED;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
        i_d = lfsr_d[0] ? NEG : POS;
        q_d = lfsr_d[1] ? NEG : POS;
    end

    // Symbol registers track the LFSR so output data is flop-driven
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
            i_q    <= LFSR_SEED[0] ? NEG : POS;
            q_q    <= LFSR_SEED[1] ? NEG : POS;
        end else begin
            lfsr_q <= lfsr_d;
            i_q    <= i_d;
            q_q    <= q_d;
        end
    end

    assign i_data = i_q;
    assign q_data = q_q;

endmodule

// File: rtl/preamble_gen.sv
// Repeated QPSK preamble followed by payload passthrough.
// Optional guard interval of zeros: PREAMBLE_GEN_GUARD_EN.
import preamble_gen_pkg::*;

module preamble_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_LEN     = 4095,
    parameter int LEN         = 4092,
    parameter int INTERP_RATE = 64,
    parameter int NREP        = 2,
    parameter logic [DATA_WIDTH-1:0] AMPL = 16'h2000,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter int GUARD_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    input  logic [DATA_WIDTH-1:0] in_itdata,
    input  logic [DATA_WIDTH-1:0] in_qtdata,
    output logic                  out_tvalid,
    output logic                  out_tlast,
    input  logic                  out_tready,
    output logic [DATA_WIDTH-1:0] out_itdata,
    output logic [DATA_WIDTH-1:0] out_qtdata,
    output logic                  busy,
    output logic                  preamble_stb
);

    localparam int SW = $clog2(MAX_LEN + 1);
    localparam logic [7:0]    HOLD_LAST = 8'(INTERP_RATE - 1);
    localparam logic [SW-1:0] SYM_LAST  = SW'(LEN - 1);
    localparam logic [3:0]    REP_LAST  = 4'(NREP - 1);

    if (LEN < 1 || LEN > MAX_LEN) begin : g_bad_len
        $error("preamble_gen: LEN out of range");
    end
    if (INTERP_RATE < 1 || INTERP_RATE > 255) begin : g_bad_ir
        $error("preamble_gen: INTERP_RATE out of range");
    end
    if (NREP < 2 || NREP > 15) begin : g_bad_nrep
        $error("preamble_gen: NREP out of range");
    end
    if (GUARD_LEN < 1) begin : g_bad_guard
        $error("preamble_gen: GUARD_LEN must be positive");
    end

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic [SW-1:0] sym_q, sym_d;
    logic [3:0]    rep_q, rep_d;
`ifdef PREAMBLE_GEN_GUARD_EN
    localparam logic [15:0] GUARD_LAST = 16'(GUARD_LEN - 1);
    logic [15:0]   guard_q, guard_d;
`endif

    logic                  flush;
    logic                  out_hs;
    logic                  lfsr_load;
    logic                  lfsr_step;
    logic [DATA_WIDTH-1:0] sym_i;
    logic [DATA_WIDTH-1:0] sym_q_data;

    assign flush  = reset | clear;
    assign out_hs = out_tvalid & out_tready;
    assign busy   = (state_q != ST_IDLE);

    preamble_lfsr_qpsk #(
        .DATA_WIDTH (DATA_WIDTH),
        .AMPL       (AMPL),
        .LFSR_SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (flush),
        .load   (lfsr_load),
        .step   (lfsr_step),
        .i_data (sym_i),
        .q_data (sym_q_data)
    );

    // Sequencing: counters advance only on an output handshake
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        sym_d     = sym_q;
        rep_d     = rep_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
`ifdef PREAMBLE_GEN_GUARD_EN
        guard_d   = guard_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRE;
                    lfsr_load = 1'b1;
                end
            end
            ST_PRE: begin
                if (out_hs) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        if (sym_q == SYM_LAST) begin
                            sym_d     = '0;
                            lfsr_load = 1'b1;
                            if (rep_q == REP_LAST) begin
                                rep_d = '0;
`ifdef PREAMBLE_GEN_GUARD_EN
                                state_d = ST_GUARD;
`else
                                state_d = ST_PAY;
`endif
                            end else begin
                                rep_d = rep_q + 4'd1;
                            end
                        end else begin
                            sym_d     = sym_q + 1'b1;
                            lfsr_step = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
            end
`ifdef PREAMBLE_GEN_GUARD_EN
            ST_GUARD: begin
                if (out_hs) begin
                    if (guard_q == GUARD_LAST) begin
                        guard_d = '0;
                        state_d = ST_PAY;
                    end else begin
                        guard_d = guard_q + 16'd1;
                    end
                end
            end
`endif
            ST_PAY: begin
                if (in_tvalid && out_tready && in_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output mux: LFSR symbols, guard zeros or payload passthrough
    always_comb begin
        out_tvalid   = 1'b0;
        out_tlast    = 1'b0;
        out_itdata   = '0;
        out_qtdata   = '0;
        in_tready    = 1'b0;
        preamble_stb = 1'b0;
        case (state_q)
            ST_PRE: begin
                out_tvalid   = 1'b1;
                out_itdata   = sym_i;
                out_qtdata   = sym_q_data;
                preamble_stb = out_tready && hold_q == '0 &&
                               sym_q == '0 && rep_q == '0;
            end
            ST_GUARD: begin
                out_tvalid = 1'b1;
            end
            ST_PAY: begin
                out_tvalid = in_tvalid;
                out_tlast  = in_tlast;
                out_itdata = in_itdata;
                out_qtdata = in_qtdata;
                in_tready  = out_tready;
            end
            default: ;
        endcase
    end

    // State and counter registers; clear acts exactly like reset
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            sym_q   <= '0;
            rep_q   <= '0;
`ifdef PREAMBLE_GEN_GUARD_EN
            guard_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sym_q   <= sym_d;
            rep_q   <= rep_d;
`ifdef PREAMBLE_GEN_GUARD_EN
            guard_q <= guard_d;
`endif
        end
    end

endmodule

// File: tb/tb_preamble_gen.sv
// Directed bench for preamble_gen: LEN=4, INTERP_RATE=2, NREP=2.
// Covers reset, back-to-back, random backpressure, ignored starts, abort.
module tb_preamble_gen;

    logic        clk = 1'b0;
    logic        reset, clear, start;
    logic        in_tvalid, in_tlast, in_tready;
    logic [15:0] in_itdata, in_qtdata;
    logic        out_tvalid, out_tlast, out_tready;
    logic [15:0] out_itdata, out_qtdata;
    logic        busy, preamble_stb;

    int vectors = 0;
    int miscompares = 0;

    // Hand-derived symbols: seed ACE1 -> 5670 -> AB38 -> 559C
    logic [15:0] pre_i [4] = '{16'hE000, 16'h2000, 16'h2000, 16'h2000};

    always #5 clk = ~clk;

    preamble_gen #(
        .DATA_WIDTH  (16),
        .MAX_LEN     (4095),
        .LEN         (4),
        .INTERP_RATE (2),
        .NREP        (2),
        .AMPL        (16'h2000),
        .LFSR_SEED   (16'hACE1),
        .GUARD_LEN   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .start        (start),
        .in_tvalid    (in_tvalid),
        .in_tlast     (in_tlast),
        .in_tready    (in_tready),
        .in_itdata    (in_itdata),
        .in_qtdata    (in_qtdata),
        .out_tvalid   (out_tvalid),
        .out_tlast    (out_tlast),
        .out_tready   (out_tready),
        .out_itdata   (out_itdata),
        .out_qtdata   (out_qtdata),
        .busy         (busy),
        .preamble_stb (preamble_stb)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next output handshake and check it
    task automatic get_out(input string tag, input logic [15:0] ei,
                           input logic [15:0] eq, input logic el,
                           input logic estb, input logic pre,
                           input logic rnd);
        int n = 0;
        logic held = 1'b0;
        logic [31:0] hd = '0;
        forever begin
            if (rnd) out_tready = 1'($urandom_range(0, 1));
            #1;
            if (held) begin
                chk({tag, "_stable"}, {out_itdata, out_qtdata}, hd);
                held = 1'b0;
            end
            if (out_tvalid && out_tready) break;
            if (pre) chk({tag, "_no_in_tready"}, 32'(in_tready), 0);
            if (out_tvalid) begin
                held = 1'b1;
                hd   = {out_itdata, out_qtdata};
            end
            if (n == 64) begin
                chk({tag, "_timeout"}, 32'(out_tvalid & out_tready), 1);
                return;
            end
            n++;
            @(posedge clk);
            #1;
        end
        if (!rnd) chk({tag, "_bubble"}, n, 0);
        chk({tag, "_i"}, 32'(out_itdata), 32'(ei));
        chk({tag, "_q"}, 32'(out_qtdata), 32'(eq));
        chk({tag, "_tlast"}, 32'(out_tlast), 32'(el));
        chk({tag, "_stb"}, 32'(preamble_stb), 32'(estb));
        if (pre) chk({tag, "_in_tready"}, 32'(in_tready), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_packet(input logic rnd);
        in_tvalid  = 1'b1;
        in_itdata  = 16'd1;
        in_qtdata  = 16'h0101;
        in_tlast   = 1'b0;
        out_tready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("latency_valid", 32'(out_tvalid), 1);
        chk("busy_pre", 32'(busy), 1);
        for (int k = 0; k < 16; k++) begin
            start = (k == 5);
            get_out("pre", pre_i[(k >> 1) & 3], 16'h2000, 1'b0,
                    k == 0, 1'b1, rnd);
            start = 1'b0;
        end
`ifdef PREAMBLE_GEN_GUARD_EN
        for (int g = 0; g < 3; g++) begin
            get_out("guard", 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, rnd);
        end
`endif
        for (int k = 1; k <= 5; k++) begin
            in_itdata = 16'(k);
            in_qtdata = 16'(16'h0100 + k);
            in_tlast  = (k == 5);
            start     = (k == 3 || k == 5);
            get_out("pay", 16'(k), 16'(16'h0100 + k), k == 5,
                    1'b0, 1'b0, rnd);
            start = 1'b0;
        end
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_end", 32'(busy), 0);
        chk("valid_end", 32'(out_tvalid), 0);
    endtask

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        start      = 1'b0;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        in_itdata  = '0;
        in_qtdata  = '0;
        out_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_tvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", {out_itdata, out_qtdata}, 0);
        chk("rst_stb", 32'(preamble_stb), 0);
        reset = 1'b0;

        in_tvalid = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_backpressure", 32'(in_tready), 0);
        chk("idle_valid", 32'(out_tvalid), 0);

        run_packet(1'b0);
        run_packet(1'b1);

        in_tvalid  = 1'b1;
        out_tready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            get_out("abort_pre", pre_i[(k >> 1) & 3], 16'h2000, 1'b0,
                    k == 0, 1'b1, 1'b0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_valid", 32'(out_tvalid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_tready", 32'(in_tready), 0);

        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        get_out("restart", 16'hE000, 16'h2000, 1'b0, 1'b1, 1'b1, 1'b0);

        clear = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("clear_over_start", 32'(busy), 0);
        clear = 1'b0;
        start = 1'b0;
        in_tvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
